i2c_reg_target: RTL and testbench



---
 rtl/i2c_reg_target.sv | 273 +++++++++++++++++++++++++++
 tb/tb_i2c_reg_target.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_target.sv
//------------------------------------------------------------------------------
// i2c_reg_target : oversampled I2C target exposing a byte-wide register bus.
// Optional glitch filter: define I2C_TARGET_GLITCH_FILTER_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module i2c_reg_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         PTR_W       = 4,
  parameter int         HOLD_CYC    = 4,
  parameter int         FILTER_CYC  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic             busy,
  output logic [PTR_W-1:0] reg_addr,
  output logic [7:0]       reg_wdata,
  output logic             reg_we,
  output logic             reg_re,
  input  logic [7:0]       reg_rdata
);

  localparam int HOLD_W = $clog2(HOLD_CYC + 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_PTR       = 4'd3,
    S_PTR_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RDATA_ACK = 4'd8
  } state_t;

  logic r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
  logic r_scl_d, r_sda_d;
  logic w_scl, w_sda;

  // Lines idle high, so synchronizers reset to 1 to avoid phantom edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
    end else begin
      r_scl_s1 <= scl_i;
      r_scl_s2 <= r_scl_s1;
      r_sda_s1 <= sda_i;
      r_sda_s2 <= r_sda_s1;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int FLT_W = $clog2(FILTER_CYC + 1);

  logic             r_scl_f, r_sda_f;
  logic [FLT_W-1:0] r_scl_cnt, r_sda_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_f   <= 1'b1;
      r_sda_f   <= 1'b1;
      r_scl_cnt <= '0;
      r_sda_cnt <= '0;
    end else begin
      if (r_scl_s2 == r_scl_f) begin
        r_scl_cnt <= '0;
      end else if (r_scl_cnt == FLT_W'(FILTER_CYC - 1)) begin
        r_scl_f   <= r_scl_s2;
        r_scl_cnt <= '0;
      end else begin
        r_scl_cnt <= r_scl_cnt + 1'b1;
      end
      if (r_sda_s2 == r_sda_f) begin
        r_sda_cnt <= '0;
      end else if (r_sda_cnt == FLT_W'(FILTER_CYC - 1)) begin
        r_sda_f   <= r_sda_s2;
        r_sda_cnt <= '0;
      end else begin
        r_sda_cnt <= r_sda_cnt + 1'b1;
      end
    end
  end

  assign w_scl = r_scl_f;
  assign w_sda = r_sda_f;
`else
  assign w_scl = r_scl_s2;
  assign w_sda = r_sda_s2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

  state_t            r_state;
  logic [2:0]        r_bit_cnt;
  logic              r_full;
  logic [7:0]        r_shift;
  logic              r_rw;
  logic              r_ack_ok;
  logic              r_re_pend;
  logic              r_load;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_oe_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_full     <= 1'b0;
      r_shift    <= '0;
      r_rw       <= 1'b0;
      r_ack_ok   <= 1'b0;
      r_re_pend  <= 1'b0;
      r_load     <= 1'b0;
      r_hold_cnt <= '0;
      r_oe_next  <= 1'b0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_we     <= 1'b0;
      reg_re     <= 1'b0;
    end else begin
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      r_re_pend <= 1'b0;
      r_load    <= reg_re;
      if (r_load) r_shift <= reg_rdata;
      if (reg_we) reg_addr <= reg_addr + 1'b1;
      if (r_re_pend) reg_re <= 1'b1;

      // Drive changes are deferred from the SCL fall to respect data hold time.
      if (r_hold_cnt != '0) begin
        r_hold_cnt <= r_hold_cnt - 1'b1;
        if (r_hold_cnt == HOLD_W'(1)) sda_oe <= r_oe_next;
      end

      if (w_start) begin
        r_state    <= S_ADDR;
        r_bit_cnt  <= '0;
        r_full     <= 1'b0;
        busy       <= 1'b1;
        sda_oe     <= 1'b0;
        r_hold_cnt <= '0;
      end else if (w_stop) begin
        r_state    <= S_IDLE;
        r_bit_cnt  <= '0;
        r_full     <= 1'b0;
        busy       <= 1'b0;
        sda_oe     <= 1'b0;
        r_hold_cnt <= '0;
      end else begin
        if (w_scl_rise) begin
          case (r_state)
            S_ADDR, S_PTR, S_WDATA: begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == 3'd7) r_full <= 1'b1;
            end
            S_RDATA: begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == 3'd7) r_full <= 1'b1;
            end
            S_RDATA_ACK: begin
              r_ack_ok <= ~w_sda;
              if (!w_sda) begin
                reg_addr  <= reg_addr + 1'b1;
                r_re_pend <= 1'b1;
              end
            end
            default: ;
          endcase
        end

        if (w_scl_fall) begin
          case (r_state)
            S_ADDR: begin
              if (r_full) begin
                r_full <= 1'b0;
                if (r_shift[7:1] == TARGET_ADDR) begin
                  r_state    <= S_ADDR_ACK;
                  r_rw       <= r_shift[0];
                  reg_re     <= r_shift[0];
                  r_oe_next  <= 1'b1;
                  r_hold_cnt <= HOLD_W'(HOLD_CYC);
                end else begin
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
                end
              end
            end
            S_ADDR_ACK: begin
              r_state    <= r_rw ? S_RDATA : S_PTR;
              r_oe_next  <= r_rw & ~r_shift[7];
              r_hold_cnt <= HOLD_W'(HOLD_CYC);
            end
            S_PTR: begin
              if (r_full) begin
                r_full     <= 1'b0;
                reg_addr   <= r_shift[PTR_W-1:0];
                r_state    <= S_PTR_ACK;
                r_oe_next  <= 1'b1;
                r_hold_cnt <= HOLD_W'(HOLD_CYC);
              end
            end
            S_WDATA: begin
              if (r_full) begin
                r_full     <= 1'b0;
                reg_we     <= 1'b1;
                reg_wdata  <= r_shift;
                r_state    <= S_WDATA_ACK;
                r_oe_next  <= 1'b1;
                r_hold_cnt <= HOLD_W'(HOLD_CYC);
              end
            end
            S_PTR_ACK, S_WDATA_ACK: begin
              r_state    <= S_WDATA;
              r_oe_next  <= 1'b0;
              r_hold_cnt <= HOLD_W'(HOLD_CYC);
            end
            S_RDATA: begin
              if (r_full) begin
                r_full     <= 1'b0;
                r_state    <= S_RDATA_ACK;
                r_oe_next  <= 1'b0;
              end else begin
                r_shift    <= {r_shift[6:0], 1'b0};
                r_oe_next  <= ~r_shift[6];
              end
              r_hold_cnt <= HOLD_W'(HOLD_CYC);
            end
            S_RDATA_ACK: begin
              if (r_ack_ok) begin
                r_state   <= S_RDATA;
                r_oe_next <= ~r_shift[7];
              end else begin
                r_state   <= S_IDLE;
                busy      <= 1'b0;
                r_oe_next <= 1'b0;
              end
              r_hold_cnt <= HOLD_W'(HOLD_CYC);
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_reg_target.sv
//------------------------------------------------------------------------------
// tb_i2c_reg_target : directed bus-master bench for i2c_reg_target.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_i2c_reg_target;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       glitch = 1'b0;
  logic       scl_i, sda_i;
  logic       sda_oe, busy, reg_we, reg_re;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;
  logic [7:0] mem [16];

  always #5 clk = ~clk;

  assign scl_i     = scl_m;
  assign sda_i     = sda_m & ~sda_oe & ~glitch;
  assign reg_rdata = mem[reg_addr];

  i2c_reg_target dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_oe    (sda_oe),
    .busy      (busy),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata)
  );

  logic [11:0] we_log[$];
  logic [3:0]  re_log[$];
  bit          oe_seen, busy_seen, both_seen;

  always @(negedge clk) begin
    if (reg_we) we_log.push_back({reg_addr, reg_wdata});
    if (reg_re) re_log.push_back(reg_addr);
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (reg_we && reg_re) both_seen = 1'b1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic i2c_bit(input logic b, output logic r);
    sda_m = b;    wait_q();
    scl_m = 1'b1; wait_q();
    r = sda_m & ~sda_oe;
    wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_wbyte(input logic [7:0] d, output logic ack);
    logic dummy;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], dummy);
    i2c_bit(1'b1, ack);
  endtask

  task automatic i2c_rbyte(input logic mack, output logic [7:0] d);
    logic dummy;
    for (int i = 7; i >= 0; i--) i2c_bit(1'b1, d[i]);
    i2c_bit(mack, dummy);
  endtask

  task automatic clear_logs();
    we_log.delete();
    re_log.delete();
    oe_seen   = 1'b0;
    busy_seen = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic       ack, dummy;
    logic [7:0] d;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[15] = 8'h3C;
    mem[0]  = 8'hC3;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_sda_oe", sda_oe, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_reg_addr", reg_addr, 0);
    check_eq("rst_reg_we", reg_we, 0);
    check_eq("rst_reg_re", reg_re, 0);

    // Write ptr 3, data A5, 5A
    clear_logs();
    i2c_start();
    i2c_wbyte(8'h84, ack); check_eq("wr_addr_ack", ack, 0);
    i2c_wbyte(8'h03, ack); check_eq("wr_ptr_ack", ack, 0);
    i2c_wbyte(8'hA5, ack); check_eq("wr_d0_ack", ack, 0);
    i2c_wbyte(8'h5A, ack); check_eq("wr_d1_ack", ack, 0);
    check_eq("wr_busy_before_p", busy, 1);
    i2c_stop();
    check_eq("wr_busy_after_p", busy, 0);
    check_eq("wr_we_count", we_log.size(), 2);
    if (we_log.size() == 2) begin
      check_eq("wr_we0", we_log[0], 12'h3A5);
      check_eq("wr_we1", we_log[1], 12'h45A);
    end
    check_eq("wr_reg_addr", reg_addr, 5);
    check_eq("wr_re_count", re_log.size(), 0);

    // Address mismatch
    clear_logs();
    i2c_start();
    i2c_wbyte(8'h86, ack); check_eq("mm_addr_nack", ack, 1);
    check_eq("mm_busy_after_addr", busy, 0);
    i2c_wbyte(8'hFF, ack); check_eq("mm_data_nack", ack, 1);
    i2c_stop();
    check_eq("mm_oe_seen", oe_seen, 0);
    check_eq("mm_we_count", we_log.size(), 0);
    check_eq("mm_re_count", re_log.size(), 0);

    // Repeated-start read with pointer wrap
    clear_logs();
    i2c_start();
    i2c_wbyte(8'h84, ack); check_eq("rd_waddr_ack", ack, 0);
    i2c_wbyte(8'h0F, ack); check_eq("rd_ptr_ack", ack, 0);
    i2c_start();
    i2c_wbyte(8'h85, ack); check_eq("rd_raddr_ack", ack, 0);
    i2c_rbyte(1'b0, d);    check_eq("rd_byte0", d, 8'h3C);
    i2c_rbyte(1'b1, d);    check_eq("rd_byte1", d, 8'hC3);
    check_eq("rd_oe_after_nack", sda_oe, 0);
    check_eq("rd_busy_after_nack", busy, 0);
    i2c_stop();
    check_eq("rd_re_count", re_log.size(), 2);
    if (re_log.size() == 2) begin
      check_eq("rd_re0", re_log[0], 15);
      check_eq("rd_re1", re_log[1], 0);
    end
    check_eq("rd_we_count", we_log.size(), 0);
    check_eq("rd_reg_addr", reg_addr, 0);

    // STOP in the middle of a data byte
    clear_logs();
    i2c_start();
    i2c_wbyte(8'h84, ack);
    i2c_wbyte(8'h01, ack); check_eq("sp_ptr_ack", ack, 0);
    i2c_bit(1'b1, dummy); i2c_bit(1'b0, dummy);
    i2c_bit(1'b1, dummy); i2c_bit(1'b0, dummy);
    i2c_stop();
    check_eq("sp_we_count", we_log.size(), 0);
    check_eq("sp_busy", busy, 0);
    i2c_start();
    i2c_wbyte(8'h84, ack); check_eq("sp2_addr_ack", ack, 0);
    i2c_wbyte(8'h02, ack); check_eq("sp2_ptr_ack", ack, 0);
    i2c_wbyte(8'h77, ack); check_eq("sp2_data_ack", ack, 0);
    i2c_stop();
    check_eq("sp2_we_count", we_log.size(), 1);
    if (we_log.size() == 1) check_eq("sp2_we0", we_log[0], 12'h277);
    check_eq("sp2_reg_addr", reg_addr, 3);

    // Reset while the target drives a 0 data bit
    clear_logs();
    i2c_start();
    i2c_wbyte(8'h84, ack);
    i2c_wbyte(8'h05, ack);
    i2c_start();
    i2c_wbyte(8'h85, ack); check_eq("rs_addr_ack", ack, 0);
    for (int i = 0; i < 200 && !sda_oe; i++) @(negedge clk);
    check_eq("rs_driving", sda_oe, 1);
    rst = 1'b1;
    #1;
    check_eq("rs_oe_async", sda_oe, 0);
    check_eq("rs_busy_async", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rs_reg_addr", reg_addr, 0);
    clear_logs();
    for (int i = 0; i < 9; i++) i2c_bit(1'b1, dummy);
    scl_m = 1'b1;
    wait_q();
    check_eq("rs_no_oe", oe_seen, 0);
    check_eq("rs_no_busy", busy_seen, 0);
    check_eq("rs_no_re", re_log.size(), 0);

    // One-cycle SDA glitch with SCL high
    clear_logs();
    @(negedge clk) glitch = 1'b1;
    @(negedge clk) glitch = 1'b0;
    repeat (20) @(negedge clk);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    check_eq("gl_filtered", busy_seen, 0);
`else
    check_eq("gl_start_seen", busy_seen, 1);
`endif
    check_eq("gl_busy_end", busy, 0);
    check_eq("we_re_exclusive", both_seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
